// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encodings and the add/subtract mode constants.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder. The master issues operations,
// the slave (the adder) reports busy/done and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );

endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the serial adder reuses it once per bit.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop
// process a WIDTH-bit operation LSB first, one bit per clock. Subtraction
// is a + ~b + 1, so the carry flop is preset to 1 and B is inverted on load.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t        st;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] acc_nxt;

  full_adder u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // Partial result: previous bits move toward the LSB, new bit enters at the MSB.
  always_comb begin
    acc_nxt            = acc >> 1;
    acc_nxt[WIDTH-1]   = fa_s;
  end

  // Control FSM plus datapath; result registers update only on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      case (st)
        IDLE, DONE: begin
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
            carry  <= (bus.sub == MODE_ADD) ? bus.cin : 1'b1;
            cnt    <= '0;
            busy_q <= 1'b1;
            st     <= SHIFT;
          end else begin
            st     <= IDLE;
          end
        end
        SHIFT: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          acc   <= acc_nxt;
          carry <= fa_c;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            // carry here is the carry into the MSB, fa_c the carry out of it
            sum_q  <= acc_nxt;
            cout_q <= fa_c;
            ovf_q  <= carry ^ fa_c;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            st     <= DONE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH 8, 1 and 16 with hand-computed results.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  i8  ();
  serial_adder_if #(.WIDTH(1))  i1  ();
  serial_adder_if #(.WIDTH(16)) i16 ();

  serial_adder #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
  serial_adder #(.WIDTH(1))  u1  (.clk(clk), .rst(rst), .bus(i1));
  serial_adder #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start cycle 0, check busy window and held result, then the done cycle.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic s, input logic [7:0] prev,
                     input logic [7:0] es, input logic eco, input logic eov);
    i8.start = 1'b1; i8.a = a; i8.b = b; i8.cin = c; i8.sub = s;
    tick();
    i8.start = 1'b0;
    chk({tag, "_busy1"}, 64'(i8.busy), 64'd1);
    for (int k = 2; k <= 8; k++) tick();
    chk({tag, "_busy8"}, 64'(i8.busy), 64'd1);
    chk({tag, "_done8"}, 64'(i8.done), 64'd0);
    chk({tag, "_held"},  64'(i8.sum),  64'(prev));
    tick();
    chk({tag, "_done9"}, 64'(i8.done), 64'd1);
    chk({tag, "_busy9"}, 64'(i8.busy), 64'd0);
    chk({tag, "_sum"},   64'(i8.sum),  64'(es));
    chk({tag, "_cout"},  64'(i8.cout), 64'(eco));
    chk({tag, "_ovf"},   64'(i8.overflow), 64'(eov));
    tick();
    chk({tag, "_pulse"}, 64'(i8.done), 64'd0);
  endtask

  initial begin
    int dcount;
    i8.start = 0;  i8.a = '0;  i8.b = '0;  i8.cin = 0;  i8.sub = 0;
    i1.start = 0;  i1.a = '0;  i1.b = '0;  i1.cin = 0;  i1.sub = 0;
    i16.start = 0; i16.a = '0; i16.b = '0; i16.cin = 0; i16.sub = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 64'(i8.busy), 64'd0);
    chk("rst_done", 64'(i8.done), 64'd0);
    chk("rst_sum",  64'(i8.sum),  64'd0);
    chk("rst_cout", 64'(i8.cout), 64'd0);
    chk("rst_ovf",  64'(i8.overflow), 64'd0);
    chk("rst_sum16", 64'(i16.sum), 64'd0);
    tick();

    op8("add_3c5a", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h96, 1'b0, 1'b1);
    op8("add_ff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h96, 8'h00, 1'b1, 1'b0);
    op8("add_cin",  8'h10, 8'h20, 1'b1, 1'b0, 8'h00, 8'h31, 1'b0, 1'b0);
    op8("sub_0507", 8'h05, 8'h07, 1'b1, 1'b1, 8'h31, 8'hFE, 1'b0, 1'b0);
    op8("sub_8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'hFE, 8'h7F, 1'b1, 1'b1);

    // start while busy is ignored; start in the done cycle is accepted
    i8.start = 1'b1; i8.a = 8'h01; i8.b = 8'h01; i8.cin = 0; i8.sub = 0;
    tick();
    i8.start = 1'b0;
    tick(); tick();
    i8.start = 1'b1; i8.a = 8'hAA; i8.b = 8'h55; i8.cin = 1; i8.sub = 1;
    tick();
    i8.start = 1'b0;
    for (int k = 5; k <= 8; k++) tick();
    chk("ign_busy8", 64'(i8.busy), 64'd1);
    chk("ign_done8", 64'(i8.done), 64'd0);
    tick();
    chk("ign_done9", 64'(i8.done), 64'd1);
    chk("ign_sum",   64'(i8.sum),  64'h02);
    chk("ign_cout",  64'(i8.cout), 64'd0);
    i8.start = 1'b1; i8.a = 8'h0F; i8.b = 8'h01; i8.cin = 0; i8.sub = 0;
    tick();
    i8.start = 1'b0;
    chk("b2b_busy10", 64'(i8.busy), 64'd1);
    chk("b2b_done10", 64'(i8.done), 64'd0);
    chk("b2b_held10", 64'(i8.sum),  64'h02);
    for (int k = 11; k <= 17; k++) tick();
    chk("b2b_done17", 64'(i8.done), 64'd0);
    tick();
    chk("b2b_done18", 64'(i8.done), 64'd1);
    chk("b2b_sum",    64'(i8.sum),  64'h10);
    tick();

    // reset mid-operation aborts without a done pulse
    i8.start = 1'b1; i8.a = 8'h3C; i8.b = 8'h5A; i8.cin = 0; i8.sub = 0;
    tick();
    i8.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(i8.busy), 64'd0);
    chk("abort_sum",  64'(i8.sum),  64'd0);
    chk("abort_done", 64'(i8.done), 64'd0);
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (i8.done) dcount++;
    end
    chk("abort_nodone", 64'(dcount), 64'd0);
    op8("after_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0);

    // WIDTH=1: 1+1
    i1.start = 1'b1; i1.a = 1'b1; i1.b = 1'b1; i1.cin = 0; i1.sub = 0;
    tick();
    i1.start = 1'b0;
    chk("w1_busy1", 64'(i1.busy), 64'd1);
    chk("w1_done1", 64'(i1.done), 64'd0);
    tick();
    chk("w1_done2", 64'(i1.done), 64'd1);
    chk("w1_sum",   64'(i1.sum),  64'd0);
    chk("w1_cout",  64'(i1.cout), 64'd1);
    chk("w1_ovf",   64'(i1.overflow), 64'd1);
    tick();

    // WIDTH=16: 0x7FFF+1
    i16.start = 1'b1; i16.a = 16'h7FFF; i16.b = 16'h0001; i16.cin = 0; i16.sub = 0;
    tick();
    i16.start = 1'b0;
    for (int k = 2; k <= 16; k++) tick();
    chk("w16_busy16", 64'(i16.busy), 64'd1);
    chk("w16_done16", 64'(i16.done), 64'd0);
    tick();
    chk("w16_done17", 64'(i16.done), 64'd1);
    chk("w16_sum",    64'(i16.sum),  64'h8000);
    chk("w16_cout",   64'(i16.cout), 64'd0);
    chk("w16_ovf",    64'(i16.overflow), 64'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised sequential successor to the combinational adder cells in Combinational_Circuits.
- Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first.
- Uses a single full-adder cell and a carry flip-flop.
- Start/busy/done handshake; result registers hold the last result.
- Building block for area-constrained datapaths where latency is acceptable.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 1 to 64.
- CNT_W, $clog2(WIDTH+1): bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  0 = a+b+cin; 1 = a-b (a + ~b + 1); captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when result registers update.
- sum  output  WIDTH  result; registered, held until the next completion.
- cout  output  1  carry out of MSB; in sub mode 1 means no borrow (a >= b unsigned).
- overflow  output  1  signed overflow = carry-into-MSB XOR cout.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state <= IDLE.
  - busy, done, sum, cout, overflow <= 0.
  - Internal shift registers, bit counter and carry FF <= 0.
  - Reset overrides all other inputs.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1: load opA <= a; opB <= sub ? ~b : b.
  - Carry FF <= sub ? 1 : cin; cnt <= 0; go to SHIFT.
- SHIFT (busy=1), at each edge:
  - Full adder on opA[0], opB[0], carry FF.
  - Sum bit shifts into the MSB of the partial-result register; opA and opB shift right.
  - Carry FF <= carry out of the full adder; cnt <= cnt+1.
  - When cnt == WIDTH-1: latch carry-into-MSB (the carry FF value used for this bit) for the overflow calculation; go to DONE.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - sum, cout and overflow have been registered on the edge that entered DONE.
  - If start=1 in DONE: accept a new operation exactly as in IDLE (back-to-back).
  - Otherwise go to IDLE.
- Latency:
  - start high in cycle 0 gives busy=1 in cycles 1..WIDTH.
  - done=1 and new sum visible in cycle WIDTH+1.
  - Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no queueing, operands unchanged.
- sum, cout and overflow never show partial results; they change only on a completion edge.
- Reset mid-operation aborts: no done pulse; outputs are zeroed.
- WIDTH=1: a single SHIFT cycle; overflow = cin_to_bit0 XOR cout.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - No sign extension internally.
  - The counter must not wrap before reaching WIDTH-1.

Decomposition:
- Shared header serial_adder_defs.vh:
  - State encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Mode constants: MODE_ADD=1'b0, MODE_SUB=1'b1.
- Sub-module full_adder (a, b, cin -> sum, cout), combinational, instantiated once.
- Control FSM and datapath stay in serial_adder.

Test Plan:
- WIDTH=8, add 0x3C+0x5A, cin=0, start in cycle 0 -> busy high cycles 1-8; done pulse in cycle 9; sum=0x96, cout=0, overflow=1.
- Add 0xFF+0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Add 0x10+0x20, cin=1 -> sum=0x31, cout=0, overflow=0.
- Sub 0x05-0x07 -> sum=0xFE, cout=0, overflow=0. Sub 0x80-0x01 -> sum=0x7F, cout=1, overflow=1.
- Start 0x01+0x01; pulse start with 0xAA+0x55 in cycle 3 -> ignored; result 0x02 in cycle 9. Start 0x0F+0x01 during the done cycle -> accepted; done again in cycle 18 with sum=0x10.
- Start an operation, assert rst in cycle 4 -> busy=0 and sum=0 from cycle 5; no done pulse. A fresh start after reset completes normally.
- WIDTH=1: 1+1, cin=0 -> done in cycle 2, sum=0, cout=1, overflow=1. WIDTH=16: 0x7FFF+0x0001 -> sum=0x8000, overflow=1, done in cycle 17.
